mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mips_mem_pkg.sv | 54 +++++
 rtl/mem_access_ctrl_load_align.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// access size codes, I/O region default and lane/replication helpers.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h10000000;

    // Size code 11 is always rejected, so it counts as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian byte lanes touched by an aligned access.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data so every candidate lane carries it.
    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            SZ_WORD: rep = data;
            default: rep = 32'h00000000;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load aligner: picks the addressed lane(s) from a memory word,
// right-justifies them and sign- or zero-extends to 32 bits.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection, then extension according to size and signedness.
    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        o_result = 32'h00000000;
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
        case (i_size)
            SZ_BYTE: o_result = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_result = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            SZ_WORD: o_result = i_word;
            default: o_result = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a CPU access port and a single-port memory
// bank: alignment and I/O-region checks, lane enables, store replication,
// wait-stated reads and aligned, extended load results. All outputs are
// registered and computed from the next state.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          RD_WAIT = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iAddr,
    input  logic [31:0] iStoreData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oAddrErr,
    output logic [31:0] oLoadData,
    output logic [31:0] oMemAddress,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oWriteData,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemData
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_WAIT - 1);

    state_t      r_state,   w_state_nxt;
    logic [1:0]  r_wait,    w_wait_nxt;
    logic [1:0]  r_size,    w_size_nxt;
    logic        r_unsigned, w_unsigned_nxt;
    logic [1:0]  r_addr_lo, w_addr_lo_nxt;
    logic        r_addr_err, w_addr_err_nxt;
    logic [31:0] r_load_data, w_load_data_nxt;
    logic [31:0] r_mem_address, w_mem_address_nxt;
    logic [3:0]  r_byte_enable, w_byte_enable_nxt;
    logic [31:0] r_write_data, w_write_data_nxt;
    logic        r_busy, r_done, r_mem_read, r_mem_write;
    logic        w_reject;
    logic [31:0] w_aligned;

    load_align u_align (
        .i_word     (iMemData),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_aligned)
    );

    // Reject misaligned accesses and sub-word stores into the I/O region.
    always_comb begin
        w_reject = is_misaligned(iSize, iAddr[1:0]) ||
                   (iWrite && (iSize != SZ_WORD) && (iAddr >= IO_BASE));
    end

    // Next-state and next-output logic of the access state machine.
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_nxt        = r_wait;
        w_size_nxt        = r_size;
        w_unsigned_nxt    = r_unsigned;
        w_addr_lo_nxt     = r_addr_lo;
        w_addr_err_nxt    = 1'b0;
        w_load_data_nxt   = r_load_data;
        w_mem_address_nxt = r_mem_address;
        w_byte_enable_nxt = r_byte_enable;
        w_write_data_nxt  = r_write_data;
        case (r_state)
            ST_IDLE: begin
                if (iReq) begin
                    w_size_nxt     = iSize;
                    w_unsigned_nxt = iUnsigned;
                    w_addr_lo_nxt  = iAddr[1:0];
                    if (w_reject) begin
                        w_state_nxt    = ST_DONE;
                        w_addr_err_nxt = 1'b1;
                    end else if (iWrite) begin
                        w_state_nxt       = ST_WRITE;
                        w_mem_address_nxt = {iAddr[31:2], 2'b00};
                        w_byte_enable_nxt = lane_enable(iSize, iAddr[1:0]);
                        w_write_data_nxt  = store_replicate(iSize, iStoreData);
                    end else begin
                        w_state_nxt       = ST_RD_ADDR;
                        w_wait_nxt        = WAIT_INIT;
                        w_mem_address_nxt = {iAddr[31:2], 2'b00};
                        w_byte_enable_nxt = lane_enable(iSize, iAddr[1:0]);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state_nxt       = ST_DONE;
                w_mem_address_nxt = 32'h00000000;
                w_byte_enable_nxt = 4'b0000;
                w_write_data_nxt  = 32'h00000000;
            end
            ST_RD_ADDR: begin
                if (r_wait == 2'd0) begin
                    w_state_nxt = ST_RD_DATA;
                end else begin
                    w_wait_nxt = r_wait - 2'd1;
                end
            end
            ST_RD_DATA: begin
                w_state_nxt       = ST_DONE;
                w_load_data_nxt   = w_aligned;
                w_mem_address_nxt = 32'h00000000;
                w_byte_enable_nxt = 4'b0000;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_mem_address_nxt = 32'h00000000;
                w_byte_enable_nxt = 4'b0000;
                w_write_data_nxt  = 32'h00000000;
            end
        endcase
    end

    // State, captured request fields and registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state       <= ST_IDLE;
            r_wait        <= 2'd0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_addr_lo     <= 2'b00;
            r_addr_err    <= 1'b0;
            r_load_data   <= 32'h00000000;
            r_mem_address <= 32'h00000000;
            r_byte_enable <= 4'b0000;
            r_write_data  <= 32'h00000000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait        <= w_wait_nxt;
            r_size        <= w_size_nxt;
            r_unsigned    <= w_unsigned_nxt;
            r_addr_lo     <= w_addr_lo_nxt;
            r_addr_err    <= w_addr_err_nxt;
            r_load_data   <= w_load_data_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_byte_enable <= w_byte_enable_nxt;
            r_write_data  <= w_write_data_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_done        <= (w_state_nxt == ST_DONE);
            r_mem_read    <= (w_state_nxt == ST_RD_ADDR);
            r_mem_write   <= (w_state_nxt == ST_WRITE);
        end
    end

    assign oBusy       = r_busy;
    assign oDone       = r_done;
    assign oAddrErr    = r_addr_err;
    assign oLoadData   = r_load_data;
    assign oMemAddress = r_mem_address;
    assign oByteEnable = r_byte_enable;
    assign oWriteData  = r_write_data;
    assign oMemRead    = r_mem_read;
    assign oMemWrite   = r_mem_write;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// sequences for reset and request-while-busy, then randomized accesses checked
// against a byte-arithmetic reference model.
module tb_mem_access_ctrl;

    localparam logic [31:0] IO_BASE = 32'h10000000;
    localparam int          RD_WAIT = 1;

    logic        iCLK, iRST, iReq, iWrite, iUnsigned;
    logic [1:0]  iSize;
    logic [31:0] iAddr, iStoreData, iMemData;
    logic        oBusy, oDone, oAddrErr, oMemRead, oMemWrite;
    logic [31:0] oLoadData, oMemAddress, oWriteData;
    logic [3:0]  oByteEnable;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] model_load;

    mem_access_ctrl #(.IO_BASE(IO_BASE), .RD_WAIT(RD_WAIT)) dut (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWrite(iWrite), .iSize(iSize),
        .iUnsigned(iUnsigned), .iAddr(iAddr), .iStoreData(iStoreData),
        .oBusy(oBusy), .oDone(oDone), .oAddrErr(oAddrErr), .oLoadData(oLoadData),
        .oMemAddress(oMemAddress), .oByteEnable(oByteEnable), .oWriteData(oWriteData),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .iMemData(iMemData)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] mdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[17];

    // Reference: size in bytes, lane offset, shifts and masks.
    task automatic ref_model(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] mdata, input logic [31:0] prev,
                             output logic err, output logic [3:0] be,
                             output logic [31:0] wd, output logic [31:0] ld);
        int nbytes;
        int off;
        logic [31:0] mask;
        logic [31:0] val;
        nbytes = 1 << size;
        off    = int'(addr[1:0]);
        err = (size == 2'd3) || ((addr[1:0] & 2'(nbytes - 1)) != 2'd0) ||
              (wr && nbytes < 4 && addr >= IO_BASE);
        be = 4'd0;
        wd = 32'd0;
        ld = prev;
        if (!err) begin
            be   = 4'(((32'd1 << nbytes) - 32'd1) << off);
            mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            if (wr) begin
                wd = (sdata & mask) * ((nbytes == 1) ? 32'h01010101 :
                                       (nbytes == 2) ? 32'h00010001 : 32'h00000001);
            end else begin
                val = (mdata >> (8 * off)) & mask;
                if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
                ld = val;
            end
        end
    endtask

    // Issue one access and observe it cycle by cycle until oDone (bounded).
    task automatic run_access(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] mdata, input logic pulse,
                              output int lat, output logic err, output int nwr,
                              output int nrd, output int extra, output int bad,
                              output logic [3:0] be, output logic [31:0] wd,
                              output logic [31:0] ma, output logic [31:0] ld,
                              output logic [31:0] ma_done, output logic idle_ok);
        @(negedge iCLK);
        iReq = 1'b1; iWrite = wr; iSize = size; iUnsigned = uns;
        iAddr = addr; iStoreData = sdata; iMemData = mdata;
        lat = 0; err = 1'b0; nwr = 0; nrd = 0; extra = 0; bad = 0;
        be = 4'd0; wd = 32'd0; ma = 32'd0; ld = 32'd0; ma_done = 32'd0; idle_ok = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge iCLK);
            iReq = (pulse && c == 1) ? 1'b1 : 1'b0;
            if (oAddrErr && !oDone) bad++;
            if (oMemWrite) begin nwr++; be = oByteEnable; wd = oWriteData; ma = oMemAddress; end
            if (oMemRead)  begin nrd++; be = oByteEnable; ma = oMemAddress; end
            if (oDone) begin
                lat = c; err = oAddrErr; ld = oLoadData; ma_done = oMemAddress;
                break;
            end
            if (!oBusy) bad++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            iReq = 1'b0;
            if (oDone) extra++;
            if (k == 0) idle_ok = !oBusy && !oMemRead && !oMemWrite && (oMemAddress == 32'd0);
        end
    endtask

    task automatic apply_check(input string tag, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] mdata,
                               input logic pulse, input logic exp_err,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd,
                               input logic [31:0] exp_ld);
        int lat, nwr, nrd, extra, bad;
        logic err, idle_ok;
        logic [3:0]  be;
        logic [31:0] wd, ma, ld, ma_done;
        int exp_lat;
        exp_lat = exp_err ? 1 : (wr ? 2 : RD_WAIT + 2);
        run_access(wr, size, uns, addr, sdata, mdata, pulse, lat, err, nwr, nrd, extra, bad,
                   be, wd, ma, ld, ma_done, idle_ok);
        check({tag, " latency"},    32'(lat), 32'(exp_lat));
        check({tag, " addr_err"},   32'(err), 32'(exp_err));
        check({tag, " write_cyc"},  32'(nwr), (!exp_err && wr) ? 32'd1 : 32'd0);
        check({tag, " read_cyc"},   32'(nrd), (!exp_err && !wr) ? 32'(RD_WAIT) : 32'd0);
        check({tag, " byte_en"},    32'(be),  32'(exp_be));
        check({tag, " wdata"},      wd, exp_wd);
        check({tag, " mem_addr"},   ma, exp_err ? 32'd0 : {addr[31:2], 2'b00});
        check({tag, " load_data"},  ld, exp_ld);
        check({tag, " addr_done"},  ma_done, 32'd0);
        check({tag, " extra_done"}, 32'(extra), 32'd0);
        check({tag, " protocol"},   32'(bad), 32'd0);
        check({tag, " idle_after"}, 32'(idle_ok), 32'd1);
    endtask

    initial begin
        int dones;
        logic r_err;
        logic [3:0]  r_be;
        logic [31:0] r_wd, r_ld, r_addr;
        logic [1:0]  r_size;
        logic        r_wr, r_uns;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h00000103, 32'h0,        32'h80FF7F01, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        32'h80FF7F01, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h00000202, 32'h1234ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD, 32'h00000080};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h00000202, 32'h0,        32'h7FFF0000, 1'b0, 4'b1100, 32'h0,        32'h00007FFF};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h00000101, 32'h0,        32'h11111111, 1'b1, 4'b0000, 32'h0,        32'h00007FFF};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h00000001, 32'h0,        32'h22222222, 1'b1, 4'b0000, 32'h0,        32'h00007FFF};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h10000000, 32'h00000055, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h00007FFF};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h12345678, 1'b0, 4'b1111, 32'h0,        32'h12345678};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h10000000, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h12345678};
        vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h00000002, 32'h0,        32'h8001FFFE, 1'b0, 4'b1100, 32'h0,        32'h00008001};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h00000002, 32'h0,        32'h8001FFFE, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[12] = '{1'b1, 2'd0, 1'b0, 32'h0FFFFFFF, 32'h0000005A, 32'h0,        1'b0, 4'b1000, 32'h5A5A5A5A, 32'hFFFF8001};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h00000000, 32'h0,        32'h33333333, 1'b1, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h00000040, 32'h0,        32'h000000F7, 1'b0, 4'b0001, 32'h0,        32'hFFFFFFF7};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h10000002, 32'h0000BEEF, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hFFFFFFF7};
        vecs[16] = '{1'b1, 2'd0, 1'b0, 32'h00000041, 32'h000000A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 32'hFFFFFFF7};

        iRST = 1'b1; iReq = 1'b0; iWrite = 1'b0; iSize = 2'd0; iUnsigned = 1'b0;
        iAddr = 32'd0; iStoreData = 32'd0; iMemData = 32'd0;
        repeat (2) @(negedge iCLK);
        check("reset busy",      32'(oBusy), 32'd0);
        check("reset done",      32'(oDone), 32'd0);
        check("reset strobes",   32'({oMemRead, oMemWrite, oAddrErr}), 32'd0);
        check("reset load_data", oLoadData, 32'd0);
        check("reset mem_addr",  oMemAddress, 32'd0);
        @(posedge iCLK);
        #2 iRST = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            apply_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].uns,
                        vecs[i].addr, vecs[i].sdata, vecs[i].mdata, 1'b0,
                        vecs[i].err, vecs[i].be, vecs[i].wdata, vecs[i].load);
        end

        // Request pulsed while a load sits in RD_ADDR must be ignored.
        apply_check("busy_req", 1'b0, 2'd2, 1'b0, 32'h00000200, 32'h0, 32'h0BADF00D, 1'b1,
                    1'b0, 4'b1111, 32'h0, 32'h0BADF00D);

        // Reset while the write strobe is up: strobe falls without a clock edge.
        @(negedge iCLK);
        iReq = 1'b1; iWrite = 1'b1; iSize = 2'd2; iAddr = 32'h00000300; iStoreData = 32'h01020304;
        @(negedge iCLK);
        iReq = 1'b0;
        check("rst_wr strobe_before", 32'(oMemWrite), 32'd1);
        #1 iRST = 1'b1;
        #1;
        check("rst_wr strobe_after", 32'(oMemWrite), 32'd0);
        check("rst_wr busy",         32'(oBusy), 32'd0);
        check("rst_wr mem_addr",     oMemAddress, 32'd0);
        check("rst_wr load_data",    oLoadData, 32'd0);
        #1 iRST = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge iCLK);
            if (oDone) dones++;
        end
        check("rst_wr no_done", 32'(dones), 32'd0);
        apply_check("post_rst", 1'b0, 2'd0, 1'b1, 32'h00000302, 32'h0, 32'hAABBCCDD, 1'b0,
                    1'b0, 4'b0100, 32'h0, 32'h000000BB);
        model_load = 32'h000000BB;

        // Randomized accesses against the reference model.
        for (int n = 0; n < 150; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_uns  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       r_addr = $urandom & 32'h00000FFF;
                1:       r_addr = IO_BASE - 32'd4 + 32'($urandom_range(0, 7));
                2:       r_addr = $urandom;
                default: r_addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            iMemData = $urandom;
            ref_model(r_wr, r_size, r_uns, r_addr, 32'($urandom), iMemData, model_load,
                      r_err, r_be, r_wd, r_ld);
            apply_check($sformatf("rnd%0d", n), r_wr, r_size, r_uns, r_addr, iStoreData_pick(r_wd, r_size),
                        iMemData, 1'b0, r_err, r_be, r_wd, r_ld);
            model_load = r_ld;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Store data whose low lanes reproduce the modelled replication; upper
    // bits are randomized so the DUT must ignore them for sub-word stores.
    function automatic logic [31:0] iStoreData_pick(input logic [31:0] wd, input logic [1:0] size);
        logic [31:0] junk;
        junk = $urandom;
        case (size)
            2'd0:    return {junk[31:8], wd[7:0]};
            2'd1:    return {junk[31:16], wd[15:0]};
            2'd2:    return wd;
            default: return junk;
        endcase
    endfunction

endmodule
